// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA timing constants (640x480 @ 60 Hz defaults) and the
//               8-bit RGB332 colour type used by the timing block and by the
//               overlay generators that feed it.
// Contents    : c_* timing constants, rgb332_t, rgb332_pack().
// Config      : none (VGA_CLKDIV_EN is consumed by vga_timing only).
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Counter width shared by hcount / vcount.
  localparam int unsigned c_CNT_W     = 10;

  // Horizontal timing, in pixels.
  localparam int unsigned c_H_VISIBLE = 640;
  localparam int unsigned c_H_FP      = 16;
  localparam int unsigned c_H_SYNC    = 96;
  localparam int unsigned c_H_BP      = 48;
  localparam int unsigned c_H_TOTAL   = c_H_VISIBLE + c_H_FP + c_H_SYNC + c_H_BP;

  // Vertical timing, in lines.
  localparam int unsigned c_V_VISIBLE = 480;
  localparam int unsigned c_V_FP      = 10;
  localparam int unsigned c_V_SYNC    = 2;
  localparam int unsigned c_V_BP      = 33;
  localparam int unsigned c_V_TOTAL   = c_V_VISIBLE + c_V_FP + c_V_SYNC + c_V_BP;

  // RGB332 pixel: red in the top three bits, blue in the bottom two.
  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } rgb332_t;

  function automatic rgb332_t rgb332_pack(input logic [2:0] red,
                                          input logic [2:0] green,
                                          input logic [1:0] blue);
    rgb332_t px;
    px.red   = red;
    px.green = green;
    px.blue  = blue;
    return px;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_counter
// Description : Wrap counter 0..MAX with a tick enable. carry_o is high during
//               the cycle in which a tick will wrap the counter back to 0, so
//               it can directly enable a cascaded counter.
// Ports       : clock_i  - clock
//               reset_i  - synchronous active-high reset (count -> 0)
//               tick_i   - advance enable
//               count_o  - current count
//               carry_o  - tick_i while count is at MAX (wrap this tick)
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module vga_counter
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH = c_CNT_W,
  parameter int unsigned MAX   = c_H_TOTAL - 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             tick_i,
  output logic [WIDTH-1:0] count_o,
  output logic             carry_o
);

  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             w_at_max;

  // ">=" rather than "==" so the counter can never run past MAX, even if a
  // value above it were ever loaded.
  assign w_at_max = (count_q >= c_MAX);

  always_comb begin
    count_d = count_q;
    if (tick_i) begin
      count_d = w_at_max ? '0 : (count_q + c_ONE);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign carry_o = tick_i & w_at_max;

endmodule
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : VGA raster timing generator and output stage. Produces the
//               pixel counters for the overlay generators, a frame-start pulse,
//               active-low syncs and the registered RGB332 pixel colour.
// Ports       : clock_i              - system clock
//               reset_i              - synchronous active-high reset
//               hcount_o / vcount_o  - current column / line
//               frame_start_o        - one clock pulse when counters wrap to 0/0
//               ov_red_i/green/blue  - overlay colour (one pixel behind counters)
//               ov_data_i            - overlay claims the pixel
//               vga_hsync_o/vsync_o  - active-low syncs (2 pixels behind counters)
//               vga_red_o/green/blue - registered colour to the connector
// Config      : VGA_CLKDIV_EN - when defined, a pixel tick occurs every second
//               clock (e.g. 50 MHz clock -> 25 MHz pixel rate); otherwise every
//               clock is a pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = c_H_VISIBLE,
  parameter int unsigned H_FP      = c_H_FP,
  parameter int unsigned H_SYNC    = c_H_SYNC,
  parameter int unsigned H_BP      = c_H_BP,
  parameter int unsigned V_VISIBLE = c_V_VISIBLE,
  parameter int unsigned V_FP      = c_V_FP,
  parameter int unsigned V_SYNC    = c_V_SYNC,
  parameter int unsigned V_BP      = c_V_BP,
  parameter logic [7:0]  BG_COLOR  = 8'h00
) (
  input  logic       clock_i,
  input  logic       reset_i,
  output logic [9:0] hcount_o,
  output logic [9:0] vcount_o,
  output logic       frame_start_o,
  input  logic [2:0] ov_red_i,
  input  logic [2:0] ov_green_i,
  input  logic [1:0] ov_blue_i,
  input  logic       ov_data_i,
  output logic       vga_hsync_o,
  output logic       vga_vsync_o,
  output logic [2:0] vga_red_o,
  output logic [2:0] vga_green_o,
  output logic [1:0] vga_blue_o
);

  localparam int unsigned c_LINE_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned c_FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Comparison limits at counter width.
  localparam logic [9:0] c_H_ACT_END = 10'(H_VISIBLE);
  localparam logic [9:0] c_V_ACT_END = 10'(V_VISIBLE);
  localparam logic [9:0] c_HS_FIRST  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] c_HS_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_VS_FIRST  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] c_VS_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  // --------------------------------------------------------------------------
  // Pixel tick
  // --------------------------------------------------------------------------
  logic w_tick;

`ifdef VGA_CLKDIV_EN
  // Phase starts at 0 after reset, so the first tick lands on the second
  // clock after release.
  logic phase_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
    end
  end

  assign w_tick = phase_q;
`else
  assign w_tick = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Horizontal / vertical counters; the line counter advances on line wrap.
  // --------------------------------------------------------------------------
  logic [9:0] w_hcount;
  logic [9:0] w_vcount;
  logic       w_hcarry;
  logic       w_vcarry;

  vga_counter #(
    .WIDTH (c_CNT_W),
    .MAX   (c_LINE_TOTAL - 1)
  ) u_hcnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .tick_i  (w_tick),
    .count_o (w_hcount),
    .carry_o (w_hcarry)
  );

  vga_counter #(
    .WIDTH (c_CNT_W),
    .MAX   (c_FRAME_LINES - 1)
  ) u_vcnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .tick_i  (w_hcarry),
    .count_o (w_vcount),
    .carry_o (w_vcarry)
  );

  // --------------------------------------------------------------------------
  // Raw sync / blank decoded from the current counters
  // --------------------------------------------------------------------------
  logic w_hsync_raw;
  logic w_vsync_raw;
  logic w_blank_raw;

  always_comb begin
    w_hsync_raw = ~((w_hcount >= c_HS_FIRST) && (w_hcount <= c_HS_LAST));
    w_vsync_raw = ~((w_vcount >= c_VS_FIRST) && (w_vcount <= c_VS_LAST));
    w_blank_raw = (w_hcount >= c_H_ACT_END) || (w_vcount >= c_V_ACT_END);
  end

  // --------------------------------------------------------------------------
  // Output pipeline. Syncs take two pixel stages. Blank needs only its first
  // stage: the colour register itself is the second stage, which lines the
  // colour up with the syncs and with the overlay's one-pixel latency.
  // --------------------------------------------------------------------------
  logic    hsync1_q;
  logic    hsync2_q;
  logic    vsync1_q;
  logic    vsync2_q;
  logic    blank1_q;
  logic    frame_start_q;
  rgb332_t rgb_q;
  rgb332_t rgb_d;

  always_comb begin
    rgb_d = rgb332_t'(BG_COLOR);
    if (blank1_q) begin
      rgb_d = '0;
    end else if (ov_data_i) begin
      rgb_d = rgb332_pack(ov_red_i, ov_green_i, ov_blue_i);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hsync1_q      <= 1'b1;
      hsync2_q      <= 1'b1;
      vsync1_q      <= 1'b1;
      vsync2_q      <= 1'b1;
      blank1_q      <= 1'b1;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      // The vertical carry is only raised by a tick that wraps both counters,
      // so this registers high on exactly the tick that lands on 0/0.
      frame_start_q <= w_vcarry;
      if (w_tick) begin
        hsync1_q <= w_hsync_raw;
        hsync2_q <= hsync1_q;
        vsync1_q <= w_vsync_raw;
        vsync2_q <= vsync1_q;
        blank1_q <= w_blank_raw;
        rgb_q    <= rgb_d;
      end
    end
  end

  assign hcount_o      = w_hcount;
  assign vcount_o      = w_vcount;
  assign frame_start_o = frame_start_q;
  assign vga_hsync_o   = hsync2_q;
  assign vga_vsync_o   = vsync2_q;
  assign vga_red_o     = rgb_q.red;
  assign vga_green_o   = rgb_q.green;
  assign vga_blue_o    = rgb_q.blue;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing
// Description : Self-checking bench for vga_timing. A full-size instance
//               (640x480 timing, BG 8'h25) checks line-level behaviour; a
//               reduced-timing instance (25x15, default BG) checks whole
//               frames. Expected values come from a pixel-index model.
// Config      : VGA_CLKDIV_EN - model uses two clocks per pixel when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_timing;

  // Full-size instance timing
  localparam int HV = 640, HF = 16, HS = 96, HB = 48, HT = 800;
  localparam int VV = 480, VF = 10, VS = 2,  VB = 33, VT = 525;
  localparam logic [7:0] BG = 8'h25;
  // Reduced instance timing
  localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3, SHT = 25;
  localparam int SVV = 8,  SVF = 2, SVS = 2, SVB = 3, SVT = 15;
  localparam logic [7:0] SBG = 8'h00;

`ifdef VGA_CLKDIV_EN
  localparam int CPT = 2;
`else
  localparam int CPT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Clock edges since reset was last released.
  int k = 0;
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;
  bit count_en = 1'b0;
  int b_hs_low = 0, s_vs_low = 0, s_fs_cnt = 0;

  // Full-size DUT signals
  logic [9:0] b_h, b_v;
  logic       b_fs, b_hs, b_vs, b_od;
  logic [2:0] b_r, b_g, b_or, b_og;
  logic [1:0] b_b, b_ob;
  // Reduced DUT signals
  logic [9:0] s_h, s_v;
  logic       s_fs, s_hs, s_vs, s_od;
  logic [2:0] s_r, s_g, s_or, s_og;
  logic [1:0] s_b, s_ob;

  vga_timing #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BG_COLOR(BG)
  ) u_big (
    .clock_i(clk), .reset_i(rst), .hcount_o(b_h), .vcount_o(b_v),
    .frame_start_o(b_fs), .ov_red_i(b_or), .ov_green_i(b_og), .ov_blue_i(b_ob),
    .ov_data_i(b_od), .vga_hsync_o(b_hs), .vga_vsync_o(b_vs),
    .vga_red_o(b_r), .vga_green_o(b_g), .vga_blue_o(b_b)
  );

  vga_timing #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_small (
    .clock_i(clk), .reset_i(rst), .hcount_o(s_h), .vcount_o(s_v),
    .frame_start_o(s_fs), .ov_red_i(s_or), .ov_green_i(s_og), .ov_blue_i(s_ob),
    .ov_data_i(s_od), .vga_hsync_o(s_hs), .vga_vsync_o(s_vs),
    .vga_red_o(s_r), .vga_green_o(s_g), .vga_blue_o(s_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t k=%0d: got %0h, expected %0h", name, $time, k, act, exp);
    end
  endtask

  // Overlay pattern for the full-size instance, by pixel index.
  function automatic bit b_ovd(input int p);
    int h;
    if (p < 0) return 1'b0;
    h = p % HT;
    return (h >= 96 && h <= 110) || (h >= 600);
  endfunction

  function automatic logic [7:0] b_ovc(input int p);
    int h, v;
    if (p < 0) return 8'h00;
    h = p % HT;
    v = (p / HT) % VT;
    if (h == 100) return 8'hE3;
    return 8'((h ^ (v << 3)) & 255);
  endfunction

  // Expected {hcount, vcount, frame_start, hsync, vsync, rgb} after n pixel
  // ticks (kk clocks). Syncs and colour describe pixel n-2; before two ticks
  // have passed they still hold their reset values.
  function automatic logic [30:0] model(input int n, input int kk,
      input int hv, input int hf, input int hs, input int ht,
      input int vv, input int vf, input int vs, input int vt,
      input logic [7:0] bg, input bit od, input logic [7:0] oc);
    logic [9:0] eh, ev;
    logic       efs, ehs, evs;
    logic [7:0] ergb;
    int p, ph, pv;
    eh  = 10'(n % ht);
    ev  = 10'((n / ht) % vt);
    efs = (n > 0) && (n % (ht * vt) == 0) && (kk % CPT == 0);
    if (n < 2) begin
      ehs = 1'b1; evs = 1'b1; ergb = 8'h00;
    end else begin
      p  = n - 2;
      ph = p % ht;
      pv = (p / ht) % vt;
      ehs = !(ph >= hv + hf && ph <= hv + hf + hs - 1);
      evs = !(pv >= vv + vf && pv <= vv + vf + vs - 1);
      if (ph >= hv || pv >= vv) ergb = 8'h00;
      else if (od)              ergb = oc;
      else                      ergb = bg;
    end
    return {eh, ev, efs, ehs, evs, ergb};
  endfunction

  // Compare + overlay drive, once per clock on the falling edge.
  initial begin
    logic [30:0] e;
    int n;
    b_od = 1'b0; b_or = '0; b_og = '0; b_ob = '0;
    s_od = 1'b0; s_or = '0; s_og = '0; s_ob = '0;
    forever begin
      @(negedge clk);
      n = k / CPT;
      if (armed) begin
        e = model(n, k, HV, HF, HS, HT, VV, VF, VS, VT, BG, b_ovd(n - 2), b_ovc(n - 2));
        chk("big.hcount", 32'(b_h), 32'(e[30:21]));
        chk("big.vcount", 32'(b_v), 32'(e[20:11]));
        chk("big.frame_start", 32'(b_fs), 32'(e[10]));
        chk("big.hsync", 32'(b_hs), 32'(e[9]));
        chk("big.vsync", 32'(b_vs), 32'(e[8]));
        chk("big.rgb", 32'({b_r, b_g, b_b}), 32'(e[7:0]));
        e = model(n, k, SHV, SHF, SHS, SHT, SVV, SVF, SVS, SVT, SBG, (n >= 2), 8'hFF);
        chk("small.hcount", 32'(s_h), 32'(e[30:21]));
        chk("small.vcount", 32'(s_v), 32'(e[20:11]));
        chk("small.frame_start", 32'(s_fs), 32'(e[10]));
        chk("small.hsync", 32'(s_hs), 32'(e[9]));
        chk("small.vsync", 32'(s_vs), 32'(e[8]));
        chk("small.rgb", 32'({s_r, s_g, s_b}), 32'(e[7:0]));
        if (count_en) begin
          if (k % CPT == 0 && n < HT && b_hs === 1'b0) b_hs_low++;
          if (k % CPT == 0 && n < SHT * SVT && s_vs === 1'b0) s_vs_low++;
          if (n >= 1 && n <= 2 * SHT * SVT && s_fs === 1'b1) s_fs_cnt++;
        end
      end
      // Overlay presents pixel n-1 while the counters show pixel n.
      {b_or, b_og, b_ob} = b_ovc(n - 1);
      b_od = b_ovd(n - 1);
      {s_or, s_og, s_ob} = 8'hFF;
      s_od = (n >= 1);
    end
  end

  task automatic goto(input int target);
    for (int i = 0; i < 200000 && k < target; i++) @(negedge clk);
    chk("goto.reached", 32'(k), 32'(target));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    armed = 1'b1;
    chk("rst.hcount", 32'(b_h), 32'd0);
    chk("rst.vcount", 32'(b_v), 32'd0);
    chk("rst.hsync", 32'(b_hs), 32'd1);
    chk("rst.vsync", 32'(b_vs), 32'd1);
    chk("rst.rgb", 32'({b_r, b_g, b_b}), 32'd0);
    chk("rst.frame_start", 32'(b_fs), 32'd0);
    count_en = 1'b1;
    rst = 1'b0;

    goto(1 * CPT);        chk("lit.h1", 32'(b_h), 32'd1);
                          chk("lit.no_fs_after_rst", 32'(b_fs), 32'd0);
    goto(375 * CPT);      chk("lit.small_fs", 32'(s_fs), 32'd1);
                          chk("lit.small_h0", 32'(s_h), 32'd0);
                          chk("lit.small_v0", 32'(s_v), 32'd0);
    goto(376 * CPT);      chk("lit.small_fs_off", 32'(s_fs), 32'd0);
    goto(657 * CPT);      chk("lit.hsync_657", 32'(b_hs), 32'd1);
    goto(658 * CPT);      chk("lit.hsync_658", 32'(b_hs), 32'd0);
    goto(753 * CPT);      chk("lit.hsync_753", 32'(b_hs), 32'd0);
    goto(754 * CPT);      chk("lit.hsync_754", 32'(b_hs), 32'd1);
    goto(760 * CPT);      chk("lit.small_vs_low", 32'(s_vs_low), 32'd50);
                          chk("lit.small_fs_cnt", 32'(s_fs_cnt), 32'd2);
    goto(799 * CPT);      chk("lit.h799", 32'(b_h), 32'd799);
    goto(800 * CPT - 1);  chk("lit.h799_hold", 32'(b_h), 32'd799);
                          chk("lit.v0_hold", 32'(b_v), 32'd0);
    goto(800 * CPT);      chk("lit.h_wrap", 32'(b_h), 32'd0);
                          chk("lit.v_wrap", 32'(b_v), 32'd1);
                          chk("lit.hsync_low_ticks", 32'(b_hs_low), 32'd96);
    count_en = 1'b0;

    goto((20 * HT + 101) * CPT); chk("lit.rgb_px99", 32'({b_r, b_g, b_b}), 32'hC3);
    goto((20 * HT + 102) * CPT); chk("lit.rgb_px100", 32'({b_r, b_g, b_b}), 32'hE3);
    goto((20 * HT + 120) * CPT); chk("lit.rgb_bg", 32'({b_r, b_g, b_b}), 32'h25);
    goto((20 * HT + 641) * CPT); chk("lit.rgb_px639", 32'({b_r, b_g, b_b}), 32'hDF);
    goto((20 * HT + 642) * CPT); chk("lit.rgb_px640", 32'({b_r, b_g, b_b}), 32'h00);
    goto((20 * HT + 702) * CPT); chk("lit.rgb_px700", 32'({b_r, b_g, b_b}), 32'h00);

    // Mid-line reset at hcount=400.
    goto((21 * HT + 400) * CPT);
    chk("pre_rst.h400", 32'(b_h), 32'd400);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst.hcount", 32'(b_h), 32'd0);
    chk("mid_rst.vcount", 32'(b_v), 32'd0);
    chk("mid_rst.hsync", 32'(b_hs), 32'd1);
    chk("mid_rst.vsync", 32'(b_vs), 32'd1);
    chk("mid_rst.rgb", 32'({b_r, b_g, b_b}), 32'd0);
    chk("mid_rst.frame_start", 32'(b_fs), 32'd0);
    rst = 1'b0;

    // Reset while hsync is low (hcount=700).
    goto(700 * CPT);
    chk("pre_rst.hsync_low", 32'(b_hs), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2.hsync", 32'(b_hs), 32'd1);
    chk("rst2.hcount", 32'(b_h), 32'd0);
    rst = 1'b0;
    goto(1000 * CPT);
    chk("post_rst.v1", 32'(b_v), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
